clock_set_ctrl: RTL and testbench

- Time-setting front end for the digital clock; sits upstream of the clock logic control stage.
- Debounces two raw push-buttons and runs a mode FSM to edit hour, then minute.
- Emits a one-cycle load strobe with the new time (binary hour/min/sec bytes, same 24-bit packing the control stage produces).
- Also emits a blink mask for the 7-segment display stage so the field being edited flashes.

---
 rtl/clock_set_ctrl_pkg.sv | 28 ++
 rtl/clock_set_ctrl_key_debounce.sv | 53 +++++
 rtl/clock_set_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the clock time-setting front end: state encoding,
// field limits, field offsets in the 24-bit time word and field helpers.
package clock_set_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_e;

    localparam logic [7:0] HOUR_MAX = 8'd23;
    localparam logic [7:0] MIN_MAX  = 8'd59;

    localparam int HOUR_LSB = 16;
    localparam int MIN_LSB  = 8;
    localparam int SEC_LSB  = 0;

    // Increment with wrap to zero once the field maximum has been reached.
    function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] max_v);
        return (v >= max_v) ? 8'd0 : v + 8'd1;
    endfunction

    // Out-of-range captured values are replaced by zero.
    function automatic logic [7:0] clamp_field(input logic [7:0] v, input logic [7:0] max_v);
        return (v > max_v) ? 8'd0 : v;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, and a
// one-cycle press pulse on the accepted 1->0 level change.
module key_debounce #(
    parameter int unsigned DEB_CNT = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic key_press
);

    localparam int unsigned CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only advances while the synced input disagrees with the
    // accepted level, so any bounce back restarts the qualification window.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_q & ~level_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], key_in};
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign key_level = level_q;
    assign key_press = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting front end: debounced mode/inc keys drive a RUN/SET_HOUR/SET_MIN
// editor with load strobe and blink mask. Auto-repeat: CLOCK_SET_AUTOREP_EN.
module clock_set_ctrl
    import clock_set_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CNT   = 1_000_000,
    parameter int unsigned BLINK_CNT = 12_500_000
`ifdef CLOCK_SET_AUTOREP_EN
    ,
    parameter int unsigned REP_DLY   = 25_000_000,
    parameter int unsigned REP_CNT   = 5_000_000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_mode,
    input  logic        key_inc,
    input  logic [23:0] cur_time,
    output logic [23:0] set_time,
    output logic        set_load,
    output logic [1:0]  edit_mode,
    output logic [2:0]  blink_mask
);

    localparam int unsigned BW = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CNT - 1);

    logic mode_level, mode_press;
    logic inc_level, inc_press;
    logic rep_pulse;
    logic inc_evt;

    state_e        state_q, state_d;
    logic [7:0]    hour_q, hour_d;
    logic [7:0]    min_q, min_d;
    logic          load_q, load_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;

    logic unused_mode_level;
    logic unused_sec;
    assign unused_mode_level = mode_level;
    assign unused_sec        = ^cur_time[SEC_LSB +: 8];

    key_debounce #(.DEB_CNT(DEB_CNT)) u_mode_deb (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_mode),
        .key_level (mode_level),
        .key_press (mode_press)
    );

    key_debounce #(.DEB_CNT(DEB_CNT)) u_inc_deb (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_inc),
        .key_level (inc_level),
        .key_press (inc_press)
    );

`ifdef CLOCK_SET_AUTOREP_EN
    localparam int unsigned REP_MAX = (REP_DLY > REP_CNT) ? REP_DLY : REP_CNT;
    localparam int unsigned RW      = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_arm_q, rep_arm_d;

    // First repeat fires after the initial hold delay, then once per period.
    always_comb begin
        rep_cnt_d = rep_cnt_q + 1'b1;
        rep_arm_d = rep_arm_q;
        rep_pulse = 1'b0;
        if (inc_level) begin
            rep_cnt_d = '0;
            rep_arm_d = 1'b0;
        end else if (!rep_arm_q && rep_cnt_q == RW'(REP_DLY - 1)) begin
            rep_pulse = 1'b1;
            rep_arm_d = 1'b1;
            rep_cnt_d = '0;
        end else if (rep_arm_q && rep_cnt_q == RW'(REP_CNT - 1)) begin
            rep_pulse = 1'b1;
            rep_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt_q <= '0;
            rep_arm_q <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_arm_q <= rep_arm_d;
        end
    end
`else
    logic unused_inc_level;
    assign unused_inc_level = inc_level;
    assign rep_pulse        = 1'b0;
`endif

    assign inc_evt = inc_press | rep_pulse;

    // Mode is checked first in every state, so a coincident inc is dropped.
    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        load_d  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mode_press) begin
                    state_d = ST_SET_HOUR;
                    hour_d  = clamp_field(cur_time[HOUR_LSB +: 8], HOUR_MAX);
                    min_d   = clamp_field(cur_time[MIN_LSB +: 8], MIN_MAX);
                end
            end
            ST_SET_HOUR: begin
                if (mode_press) begin
                    state_d = ST_SET_MIN;
                end else if (inc_evt) begin
                    hour_d = wrap_inc(hour_q, HOUR_MAX);
                end
            end
            ST_SET_MIN: begin
                if (mode_press) begin
                    state_d = ST_RUN;
                    load_d  = 1'b1;
                end else if (inc_evt) begin
                    min_d = wrap_inc(min_q, MIN_MAX);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Blink timebase restarts on each state change so a freshly selected
    // field always begins in the visible phase.
    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        if (state_d != state_q) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            hour_q      <= 8'd0;
            min_q       <= 8'd0;
            load_q      <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            load_q      <= load_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    always_comb begin
        blink_mask = 3'b000;
        case (state_q)
            ST_SET_HOUR: blink_mask = {phase_q, 2'b00};
            ST_SET_MIN:  blink_mask = {1'b0, phase_q, 1'b0};
            default:     blink_mask = 3'b000;
        endcase
    end

    assign set_time  = {hour_q, min_q, 8'd0};
    assign set_load  = load_q;
    assign edit_mode = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl with short debounce and blink periods.
module tb_clock_set_ctrl;

  localparam int DEB = 4;
  localparam int BLK = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_mode;
  logic        key_inc;
  logic [23:0] cur_time;
  logic [23:0] set_time;
  logic        set_load;
  logic [1:0]  edit_mode;
  logic [2:0]  blink_mask;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int load_cnt = 0;
  int inc_pulses = 0;
  int last_pulse_cyc = 0;

  // model state: edit mode and field values as plain integers
  int m_mode = 0;
  int m_h = 0;
  int m_m = 0;
  logic [23:0] exp_q[$];

  typedef struct {
    bit          do_mode;
    bit          do_inc;
    logic [23:0] cur;
    logic [1:0]  exp_mode;
    logic [23:0] exp_set;
    int          exp_loads;
  } vec_t;

  vec_t vecs[8];

  clock_set_ctrl #(.DEB_CNT(DEB), .BLINK_CNT(BLK)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_mode   (key_mode),
    .key_inc    (key_inc),
    .cur_time   (cur_time),
    .set_time   (set_time),
    .set_load   (set_load),
    .edit_mode  (edit_mode),
    .blink_mask (blink_mask)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard for load strobes
  always @(negedge clk) begin
    if (!rst && set_load) begin
      load_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load: got set_time 0x%0h with no load pending", set_time);
      end else begin
        check("load_value", {8'd0, set_time}, {8'd0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && dut.u_inc_deb.key_press) begin
      inc_pulses++;
      last_pulse_cyc = cyc;
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // reference model, expressed in terms of the user-visible rules
  task automatic model_apply(input bit m, input bit i, input logic [23:0] ct);
    int hh, mm;
    hh = int'(ct[23:16]);
    mm = int'(ct[15:8]);
    if (m) begin
      if (m_mode == 0) begin
        m_h = (hh > 23) ? 0 : hh;
        m_m = (mm > 59) ? 0 : mm;
        m_mode = 1;
      end else if (m_mode == 1) begin
        m_mode = 2;
      end else begin
        exp_q.push_back({m_h[7:0], m_m[7:0], 8'h00});
        m_mode = 0;
      end
    end else if (i) begin
      if (m_mode == 1) m_h = (m_h + 1) % 24;
      else if (m_mode == 2) m_m = (m_m + 1) % 60;
    end
  endtask

  // driver: hold keys low long enough to debounce, then release
  task automatic press(input bit m, input bit i, input logic [23:0] ct);
    model_apply(m, i, ct);
    @(posedge clk); #1;
    cur_time = ct;
    if (m) key_mode = 1'b0;
    if (i) key_inc = 1'b0;
    repeat (DEB + 4) @(posedge clk);
    #1;
    key_mode = 1'b1;
    key_inc = 1'b1;
    repeat (DEB + 4) @(posedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_mode"}, {30'd0, edit_mode}, m_mode);
    check({tag, "_set_time"}, {8'd0, set_time}, {8'd0, m_h[7:0], m_m[7:0], 8'd0});
  endtask

  // enter the next state with the mode key held, then watch the blink pattern
  task automatic blink_test(input logic [2:0] on_mask, input string tag);
    int waited;
    bit seen;
    model_apply(1'b1, 1'b0, cur_time);
    @(posedge clk); #1;
    key_mode = 1'b0;
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 20) begin
      @(negedge clk);
      waited++;
      if (edit_mode == m_mode[1:0]) seen = 1'b1;
    end
    check({tag, "_entered"}, {31'd0, seen}, 1);
    for (int k = 0; k < 4 * BLK; k++) begin
      check({tag, "_mask"}, {29'd0, blink_mask}, ((k / BLK) % 2 == 1) ? {29'd0, on_mask} : 32'd0);
      @(negedge clk);
    end
    #1;
    key_mode = 1'b1;
    repeat (DEB + 4) @(posedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_mode = 0;
    m_h = 0;
    m_m = 0;
  endtask

  initial begin
    int base_loads;
    int base_pulses;
    int c0;
    bit m;
    bit i;
    logic [23:0] ct;

    vecs[0] = '{1'b1, 1'b0, 24'h173B05, 2'd1, 24'h173B00, 0};
    vecs[1] = '{1'b0, 1'b1, 24'h173B05, 2'd1, 24'h003B00, 0};
    vecs[2] = '{1'b1, 1'b0, 24'h173B05, 2'd2, 24'h003B00, 0};
    vecs[3] = '{1'b0, 1'b1, 24'h173B05, 2'd2, 24'h000000, 0};
    vecs[4] = '{1'b0, 1'b1, 24'h173B05, 2'd2, 24'h000100, 0};
    vecs[5] = '{1'b0, 1'b1, 24'h173B05, 2'd2, 24'h000200, 0};
    vecs[6] = '{1'b1, 1'b0, 24'h173B05, 2'd0, 24'h000200, 1};
    vecs[7] = '{1'b0, 1'b1, 24'h050505, 2'd0, 24'h000200, 0};

    key_mode = 1'b1;
    key_inc = 1'b1;
    cur_time = 24'h000000;
    do_reset();

    // reset state
    @(negedge clk);
    check("rst_mode", {30'd0, edit_mode}, 0);
    check("rst_set_time", {8'd0, set_time}, 0);
    check("rst_set_load", {31'd0, set_load}, 0);
    check("rst_blink", {29'd0, blink_mask}, 0);

    // debounce: short glitches, then a stable low edge
    base_pulses = inc_pulses;
    @(posedge clk); #1;
    for (int g = 0; g < 3; g++) begin
      key_inc = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      key_inc = 1'b1;
      repeat (2) @(posedge clk);
      #1;
    end
    key_inc = 1'b0;
    c0 = cyc;
    repeat (10) @(posedge clk);
    #1;
    key_inc = 1'b1;
    repeat (10) @(posedge clk);
    check("deb_pulse_count", inc_pulses - base_pulses, 1);
    check("deb_latency", last_pulse_cyc - c0, 2 + DEB);
    check_model("deb_run_ignored");

    // table-driven edit/load sequence
    for (int v = 0; v < 8; v++) begin
      base_loads = load_cnt;
      press(vecs[v].do_mode, vecs[v].do_inc, vecs[v].cur);
      check($sformatf("vec%0d_mode", v), {30'd0, edit_mode}, {30'd0, vecs[v].exp_mode});
      check($sformatf("vec%0d_set_time", v), {8'd0, set_time}, {8'd0, vecs[v].exp_set});
      check($sformatf("vec%0d_loads", v), load_cnt - base_loads, vecs[v].exp_loads);
    end

    // minute wrap 58 -> 59 -> 0 with hour untouched
    press(1'b1, 1'b0, 24'h053A00);
    press(1'b1, 1'b0, 24'h053A00);
    press(1'b0, 1'b1, 24'h053A00);
    check("minwrap_59", {8'd0, set_time}, 32'h00053B00);
    press(1'b0, 1'b1, 24'h053A00);
    check("minwrap_0", {8'd0, set_time}, 32'h00050000);
    press(1'b1, 1'b0, 24'h053A00);
    check("minwrap_load_mode", {30'd0, edit_mode}, 0);

    // captured out-of-range fields clamp to zero
    press(1'b1, 1'b0, 24'h1F4000);
    check("clamp_set_time", {8'd0, set_time}, 32'h00000000);
    check_model("clamp");

    // coincident mode and inc in SET_HOUR: mode wins
    press(1'b1, 1'b1, 24'h123456);
    check("simul_mode", {30'd0, edit_mode}, 2);
    check("simul_set_time", {8'd0, set_time}, 32'h00000000);
    press(1'b1, 1'b0, 24'h123456);
    check_model("simul_exit");

    // blink phases in both edit states
    cur_time = 24'h0A1400;
    blink_test(3'b100, "blink_hour");
    blink_test(3'b010, "blink_min");
    check_model("blink");

    // asynchronous reset mid-edit
    base_loads = load_cnt;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("midrst_mode", {30'd0, edit_mode}, 0);
    check("midrst_blink", {29'd0, blink_mask}, 0);
    check("midrst_set_time", {8'd0, set_time}, 0);
    check("midrst_load", {31'd0, set_load}, 0);
    exp_q.delete();
    do_reset();
    repeat (20) @(posedge clk);
    check("midrst_no_load", load_cnt - base_loads, 0);

    // randomized presses against the model
    for (int n = 0; n < 50; n++) begin
      m = ($urandom_range(0, 3) == 0);
      i = !m || ($urandom_range(0, 7) == 0);
      ct = {8'($urandom_range(0, 31)), 8'($urandom_range(0, 63)), 8'($urandom_range(0, 59))};
      press(m, i, ct);
      check_model($sformatf("rand%0d", n));
    end

    repeat (5) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
